// File: rtl/hazard_fwd_unit_if.sv
// Decode/execute-side bundle for hazard_fwd_unit: decode sources, stage results and resolved operands.
interface hazard_fwd_unit_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned RA_W  = 5,
  parameter int unsigned DEPTH = 3
);
  localparam int unsigned SEL_W = $clog2(DEPTH + 1);

  logic                  id_valid;
  logic [RA_W-1:0]       id_rs1;
  logic [RA_W-1:0]       id_rs2;
  logic                  id_use_rs1;
  logic                  id_use_rs2;
  logic [RA_W-1:0]       id_rd;
  logic                  id_rd_we;
  logic                  id_is_load;
  logic                  flush;
  logic [XLEN-1:0]       rf_rs1_v;
  logic [XLEN-1:0]       rf_rs2_v;
  logic [DEPTH*XLEN-1:0] stage_data;
  logic                  stall;
  logic [SEL_W-1:0]      fwd_sel_rs1;
  logic [SEL_W-1:0]      fwd_sel_rs2;
  logic [XLEN-1:0]       rs1_v;
  logic [XLEN-1:0]       rs2_v;
  logic [SEL_W-1:0]      inflight;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_rd_we, id_is_load,
    output flush, rf_rs1_v, rf_rs2_v, stage_data,
    input  stall, fwd_sel_rs1, fwd_sel_rs2, rs1_v, rs2_v, inflight
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_rd_we, id_is_load,
    input  flush, rf_rs1_v, rf_rs2_v, stage_data,
    output stall, fwd_sel_rs1, fwd_sel_rs2, rs1_v, rs2_v, inflight
  );
endinterface

// File: rtl/hazard_fwd_unit.sv
// Multi-stage operand forwarding and load-use stall control between decode and execute.
// Optional stall/flush event counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_fwd_unit #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned RA_W       = 5,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned LOAD_STAGE = 1
) (
  input  logic             clk,
  input  logic             reset,
  hazard_fwd_unit_if.slave bus
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]      stall_cnt,
  output logic [31:0]      flush_cnt
`endif
);
  localparam int unsigned SEL_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic            valid;
    logic [RA_W-1:0] rd;
    logic            we;
    logic            is_load;
  } entry_t;

  entry_t           entry_q [DEPTH];
  entry_t           entry_d [DEPTH];
  logic             stall_c;
  logic [SEL_W-1:0] sel1_c;
  logic [SEL_W-1:0] sel2_c;
  logic             ld1_c;
  logic             ld2_c;
  logic [XLEN-1:0]  v1_c;
  logic [XLEN-1:0]  v2_c;
  logic [SEL_W-1:0] inflight_c;

  // Shift tracker; a stalled or flushed decode slot enters execute as a bubble.
  always_comb begin
    entry_d[0] = '{valid:   bus.id_valid & ~stall_c & ~bus.flush,
                   rd:      bus.id_rd,
                   we:      bus.id_rd_we,
                   is_load: bus.id_is_load};
    for (int k = 1; k < int'(DEPTH); k++) begin
      entry_d[k] = entry_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        entry_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        entry_q[k] <= entry_d[k];
      end
    end
  end

  // Scan oldest to youngest so the youngest matching producer overrides.
  always_comb begin
    sel1_c = '0;
    sel2_c = '0;
    ld1_c  = 1'b0;
    ld2_c  = 1'b0;
    v1_c   = bus.rf_rs1_v;
    v2_c   = bus.rf_rs2_v;
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      if (entry_q[k].valid && entry_q[k].we && entry_q[k].rd == bus.id_rs1 &&
          bus.id_rs1 != '0 && bus.id_use_rs1) begin
        sel1_c = SEL_W'(k + 1);
        ld1_c  = entry_q[k].is_load && (k < int'(LOAD_STAGE));
        v1_c   = bus.stage_data[k*XLEN +: XLEN];
      end
      if (entry_q[k].valid && entry_q[k].we && entry_q[k].rd == bus.id_rs2 &&
          bus.id_rs2 != '0 && bus.id_use_rs2) begin
        sel2_c = SEL_W'(k + 1);
        ld2_c  = entry_q[k].is_load && (k < int'(LOAD_STAGE));
        v2_c   = bus.stage_data[k*XLEN +: XLEN];
      end
    end
  end

  assign stall_c = bus.id_valid & (ld1_c | ld2_c);

  always_comb begin
    inflight_c = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      inflight_c = inflight_c + SEL_W'(entry_q[k].valid);
    end
  end

  assign bus.stall       = stall_c;
  assign bus.fwd_sel_rs1 = sel1_c;
  assign bus.fwd_sel_rs2 = sel2_c;
  assign bus.rs1_v       = v1_c;
  assign bus.rs2_v       = v2_c;
  assign bus.inflight    = inflight_c;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;
  logic [31:0] flush_cnt_q;
  logic [31:0] flush_cnt_d;

  // Saturating event counters; a stall coinciding with a flush is counted as a flush only.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_c && !bus.flush && stall_cnt_q != 32'hFFFF_FFFF) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (bus.flush && flush_cnt_q != 32'hFFFF_FFFF) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif
endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed vector bench for hazard_fwd_unit with default parameters (XLEN=32, RA_W=5, DEPTH=3, LOAD_STAGE=1).
module tb_hazard_fwd_unit;
  localparam logic [31:0] RF1 = 32'hA1A1_A1A1;
  localparam logic [31:0] RF2 = 32'hB2B2_B2B2;
  localparam logic [31:0] D0  = 32'h0000_1234;
  localparam logic [31:0] D1  = 32'h0000_5678;
  localparam logic [31:0] D2  = 32'h0000_9ABC;
  localparam int          NV  = 14;

  typedef struct {
    logic        vld;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        u1;
    logic        u2;
    logic [4:0]  rd;
    logic        we;
    logic        ld;
    logic        fl;
    logic        e_stall;
    logic [1:0]  e_sel1;
    logic [1:0]  e_sel2;
    logic [31:0] e_v1;
    logic [31:0] e_v2;
    logic [1:0]  e_inf;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  vec_t vec [NV];

  hazard_fwd_unit_if #(.XLEN(32), .RA_W(5), .DEPTH(3)) bus ();

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
  hazard_fwd_unit #(.XLEN(32), .RA_W(5), .DEPTH(3), .LOAD_STAGE(1)) dut (
    .clk(clk), .reset(reset), .bus(bus), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));
`else
  hazard_fwd_unit #(.XLEN(32), .RA_W(5), .DEPTH(3), .LOAD_STAGE(1)) dut (
    .clk(clk), .reset(reset), .bus(bus));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic vld, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic [4:0] rd,
                       input logic we, input logic ld, input logic fl);
    bus.id_valid   = vld;
    bus.id_rs1     = rs1;
    bus.id_rs2     = rs2;
    bus.id_use_rs1 = u1;
    bus.id_use_rs2 = u2;
    bus.id_rd      = rd;
    bus.id_rd_we   = we;
    bus.id_is_load = ld;
    bus.flush      = fl;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    bus.rf_rs1_v   = RF1;
    bus.rf_rs2_v   = RF2;
    bus.stage_data = {D2, D1, D0};
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);

    //        vld  rs1   rs2   u1 u2 rd    we ld fl   stall sel1 sel2 v1   v2   inf
    vec[0]  = '{1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0, 0,  0, 2'd0, 2'd0, RF1, RF2, 2'd0};
    vec[1]  = '{1, 5'd5, 5'd0, 1, 1, 5'd6, 1, 0, 0,  0, 2'd1, 2'd0, D0,  RF2, 2'd1};
    vec[2]  = '{1, 5'd5, 5'd6, 1, 1, 5'd7, 1, 1, 0,  0, 2'd2, 2'd1, D1,  D0,  2'd2};
    vec[3]  = '{1, 5'd5, 5'd7, 1, 1, 5'd8, 1, 0, 0,  1, 2'd3, 2'd1, D2,  D0,  2'd3};
    vec[4]  = '{1, 5'd5, 5'd7, 1, 1, 5'd8, 1, 0, 0,  0, 2'd0, 2'd2, RF1, D1,  2'd2};
    vec[5]  = '{1, 5'd8, 5'd7, 1, 1, 5'd3, 1, 0, 0,  0, 2'd1, 2'd3, D0,  D2,  2'd2};
    vec[6]  = '{1, 5'd3, 5'd8, 1, 1, 5'd3, 1, 0, 0,  0, 2'd1, 2'd2, D0,  D1,  2'd2};
    vec[7]  = '{1, 5'd3, 5'd3, 1, 0, 5'd9, 1, 0, 0,  0, 2'd1, 2'd0, D0,  RF2, 2'd3};
    vec[8]  = '{1, 5'd3, 5'd9, 1, 1, 5'd0, 1, 0, 0,  0, 2'd2, 2'd1, D1,  D0,  2'd3};
    vec[9]  = '{1, 5'd0, 5'd3, 1, 1, 5'd10, 1, 0, 1, 0, 2'd0, 2'd3, RF1, D2,  2'd3};
    vec[10] = '{1, 5'd10, 5'd9, 1, 1, 5'd11, 1, 1, 0, 0, 2'd0, 2'd3, RF1, D2, 2'd2};
    vec[11] = '{1, 5'd11, 5'd0, 1, 0, 5'd12, 1, 0, 1, 1, 2'd1, 2'd0, D0,  RF2, 2'd2};
    vec[12] = '{0, 5'd12, 5'd11, 1, 1, 5'd13, 1, 0, 0, 0, 2'd0, 2'd2, RF1, D1, 2'd1};
    vec[13] = '{1, 5'd11, 5'd11, 1, 1, 5'd7, 1, 1, 0, 0, 2'd3, 2'd3, D2,  D2,  2'd1};

    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(vec[i].vld, vec[i].rs1, vec[i].rs2, vec[i].u1, vec[i].u2,
            vec[i].rd, vec[i].we, vec[i].ld, vec[i].fl);
      #1;
      check($sformatf("v%0d stall", i),    32'(bus.stall),       32'(vec[i].e_stall));
      check($sformatf("v%0d sel_rs1", i),  32'(bus.fwd_sel_rs1), 32'(vec[i].e_sel1));
      check($sformatf("v%0d sel_rs2", i),  32'(bus.fwd_sel_rs2), 32'(vec[i].e_sel2));
      check($sformatf("v%0d rs1_v", i),    bus.rs1_v,            vec[i].e_v1);
      check($sformatf("v%0d rs2_v", i),    bus.rs2_v,            vec[i].e_v2);
      check($sformatf("v%0d inflight", i), 32'(bus.inflight),    32'(vec[i].e_inf));
      @(posedge clk);
      @(negedge clk);
    end

`ifdef HAZARD_PERF_CNT_EN
    check("stall_cnt run", stall_cnt, 32'd1);
    check("flush_cnt run", flush_cnt, 32'd2);
`endif

    // Load rd=7 now sits in execute: a consumer stalls, an invalid slot does not.
    drive(1'b1, 5'd0, 5'd7, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    check("lu stall",    32'(bus.stall),       32'd1);
    check("lu sel_rs2",  32'(bus.fwd_sel_rs2), 32'd1);
    check("lu inflight", 32'(bus.inflight),    32'd1);
    bus.id_valid = 1'b0;
    #1;
    check("novalid stall", 32'(bus.stall), 32'd0);
    bus.id_valid = 1'b1;
    #1;
    check("pre-reset stall", 32'(bus.stall), 32'd1);

    // Reset in the middle of a stall clears all tracking.
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst stall",    32'(bus.stall),       32'd0);
    check("rst inflight", 32'(bus.inflight),    32'd0);
    check("rst sel_rs1",  32'(bus.fwd_sel_rs1), 32'd0);
    check("rst sel_rs2",  32'(bus.fwd_sel_rs2), 32'd0);
    check("rst rs2_v",    bus.rs2_v,            RF2);
`ifdef HAZARD_PERF_CNT_EN
    check("rst stall_cnt", stall_cnt, 32'd0);
    check("rst flush_cnt", flush_cnt, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_fwd_unit.md
Name: hazard_fwd_unit

Overview:
- Parametrised successor to the fixed single-stage forwarding control of the fewcore pipeline.
- Tracks destination registers of all in-flight instructions across DEPTH post-decode stages.
- Selects and muxes the youngest valid forwarding source for rs1/rs2.
- Raises a load-use stall and absorbs branch flushes; sits between decode/fetch and execute.

Parameters:
- XLEN, 32, data width of register values and stage results.
- RA_W, 5, register address width; register 0 is hard-wired zero.
- DEPTH, 3, tracked stages after decode; entry 0 = execute, DEPTH-1 = writeback.
- LOAD_STAGE, 1, first entry index at which load data is valid in stage_data; range 1..DEPTH-1.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-low reset.
- id_valid  in  1  decode slot holds a real instruction.
- id_rs1, id_rs2  in  RA_W each  source register addresses.
- id_use_rs1, id_use_rs2  in  1 each  source actually read.
- id_rd  in  RA_W  destination register.
- id_rd_we  in  1  instruction writes rd.
- id_is_load  in  1  instruction is a load.
- flush  in  1  taken branch resolved in execute; kill the decode instruction.
- rf_rs1_v, rf_rs2_v  in  XLEN each  register-file read data.
- stage_data  in  DEPTH*XLEN  result of entry k at bits [k*XLEN +: XLEN].
- stall  out  1  hold fetch/decode; insert bubble into execute.
- fwd_sel_rs1, fwd_sel_rs2  out  $clog2(DEPTH+1) each  0 = register file, k+1 = entry k.
- rs1_v, rs2_v  out  XLEN each  resolved operand values.
- inflight  out  $clog2(DEPTH+1)  count of valid tracked entries.

Behaviour:
- Tracking state: a DEPTH-entry shift register. Each entry holds {valid, rd, we, is_load}.
- Every clock, entry[k] <= entry[k-1] for k ≥ 1. Entry DEPTH-1 retires.
- entry[0] <= {id_valid & ~stall & ~flush, id_rd, id_rd_we, id_is_load}.
  - A stall or flush therefore inserts a bubble into entry 0.
  - Flush has priority over stall; both asserted → bubble, and stall still shown on the output.
- Reset (reset=0 at posedge) clears every valid bit; this holds mid-operation too.
  - Cycle after reset: stall=0, fwd_sel=0, rs*_v = rf_rs*_v, inflight=0.
- Match for source s (rs1 or rs2), evaluated on entry k:
  - entry[k].valid & entry[k].we & entry[k].rd == id_s & id_s != 0 & id_use_s.
- Priority: the lowest k (youngest) match wins. Older matches are ignored.
- Forwarding: the winning k gives fwd_sel_s = k+1 and s_v = stage_data[k].
  - No match gives fwd_sel_s = 0 and s_v = rf_s_v.
  - Register 0 always resolves to rf value (expected 0), with sel 0.
- Load-use: stall = id_valid & (winning entry for rs1 or rs2 is_load & k < LOAD_STAGE).
  - The stall repeats each cycle until the load reaches LOAD_STAGE. With defaults that is 1 stall cycle.
- Same-cycle writeback: entry DEPTH-1 is forwarded, because the register file writes at the same posedge.
- stall, fwd_sel and rs*_v are combinational from current state and inputs. There is no added latency.
- inflight is popcount of valid bits, combinational.
- id_valid=0 → stall=0. Selects are still computed but are don't-care.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined, two extra outputs are added: stall_cnt [31:0] and flush_cnt [31:0].
  - stall_cnt increments on each clock with stall=1 and flush=0.
  - flush_cnt increments on each clock with flush=1.
  - Both saturate at 32'hFFFF_FFFF and clear to 0 on reset.
- When undefined, the ports and counters are absent. Remaining behaviour is identical.

Test Plan:
- ALU forward, EX: issue rd=5 (we, non-load). Next cycle rs1=5, stage_data[0]=32'h1234 → fwd_sel_rs1=1, rs1_v=32'h1234, stall=0.
- Load-use: load rd=7. Next cycle rs2=7 → stall=1 for exactly 1 cycle, entry 0 bubble. Following cycle fwd_sel_rs2=2, rs2_v=stage_data[1].
- Youngest priority: rd=3 written by entries 0 and 2 with different data → fwd_sel=1, data from entry 0. Writeback-only match (entry 2) → fwd_sel=3.
- x0 and unused sources:
  - rd=0 we=1 in entry 0, rs1=0 → fwd_sel_rs1=0, rs1_v=rf_rs1_v.
  - id_use_rs2=0 with a matching entry → fwd_sel_rs2=0, no stall.
- Flush: flush=1 with id_valid=1 → next cycle entry 0 invalid; a dependent instruction sees no match from it. flush+stall together → bubble only.
- Reset mid-operation: load in flight causing stall=1, then reset=0 for one posedge → stall=0, inflight=0, all sel=0. With HAZARD_PERF_CNT_EN, counters read 0.
